// File: rtl/jh_pe_loader.sv
// Host-side loader for the PE array's load port: converts a valid/ready stream of
// node values into registered per-PE memory writes, and stalls while the array computes.
module jh_pe_loader #(
  parameter int unsigned N_ADDR = 110,
  parameter int unsigned PE_W   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [PE_W-1:0] first_pe,
  input  logic [6:0]      num_pe,
  input  logic            computing_on,
  input  logic [26:0]     s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic [PE_W-1:0] target_pe,
  output logic [6:0]      addr,
  output logic [26:0]     data,
  output logic            we,
  output logic            busy,
  output logic            done,
  output logic            start_err
);

  localparam logic [6:0] ADDR_LAST = 7'(N_ADDR - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [PE_W-1:0] pe_cnt;
  logic [6:0]      addr_cnt;
  logic [6:0]      left;
  logic            accept;
  logic            start_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    accept   = 1'b0;
    start_ok = 1'b0;
    case (state)
      S_IDLE: begin
        start_ok = start && !computing_on;
        if (start_ok) state_nx = S_LOAD;
      end
      S_LOAD: begin
        // Ready drops combinationally so no word is taken in the cycle computing starts.
        s_ready = !computing_on;
        accept  = s_valid && !computing_on;
        if (accept && (left == 7'd1) && (addr_cnt == ADDR_LAST)) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pe_cnt    <= '0;
      addr_cnt  <= '0;
      left      <= '0;
      target_pe <= '0;
      addr      <= '0;
      data      <= '0;
      we        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
    end else begin
      we        <= accept;
      busy      <= (state_nx != S_IDLE);
      done      <= (state == S_DONE);
      start_err <= (state == S_IDLE) && start && computing_on;
      if (start_ok) begin
        pe_cnt   <= first_pe;
        addr_cnt <= '0;
        left     <= (num_pe == 7'd0) ? 7'd1 : num_pe;
      end else if (accept) begin
        target_pe <= pe_cnt;
        addr      <= addr_cnt;
        data      <= s_data;
        if (addr_cnt == ADDR_LAST) begin
          addr_cnt <= '0;
          pe_cnt   <= pe_cnt + 1'b1;
          left     <= left - 1'b1;
        end else begin
          addr_cnt <= addr_cnt + 1'b1;
        end
      end
    end
  end

endmodule
